minor_engine_arbiter: RTL and testbench

MINOR_ENGINE_ARBITER -- requirements
Module: minor_engine_arbiter

---
 rtl/minor_engine_arbiter.sv | 140 ++++++++++++++
 tb/tb_minor_engine_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minor_engine_arbiter.sv
// Round-robin arbiter sharing one 2x2 determinant core among three requesters,
// with a watchdog that turns a missing core_done into an error response.
module minor_engine_arbiter #(
  parameter int unsigned DW  = 8,
  parameter int unsigned TMO = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [4*DW-1:0] opnd0,
  input  logic [4*DW-1:0] opnd1,
  input  logic [4*DW-1:0] opnd2,
  output logic [2:0]      grant,
  output logic            core_start,
  output logic [DW-1:0]   core_a,
  output logic [DW-1:0]   core_b,
  output logic [DW-1:0]   core_c,
  output logic [DW-1:0]   core_d,
  input  logic            core_done,
  input  logic [2*DW:0]   core_result,
  output logic [2:0]      resp_valid,
  output logic [2*DW:0]   resp_data,
  output logic            resp_err
);

  localparam int unsigned CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] CntLast = CW'(TMO - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [2:0]      grant_q, grant_d;
  logic [4*DW-1:0] opnd_q, opnd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*DW:0]   res_q, res_d;
  logic            err_q, err_d;

  logic            win_found;
  logic [1:0]      win_idx;
  logic [4*DW-1:0] win_opnd;

  function automatic logic [1:0] rr_pos(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Walk the search order backwards so the earliest requester in the order wins.
  always_comb begin
    win_found = |req;
    win_idx   = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (req[rr_pos(ptr_q, 2'(k))]) win_idx = rr_pos(ptr_q, 2'(k));
    end
  end

  always_comb begin
    case (win_idx)
      2'd0:    win_opnd = opnd0;
      2'd1:    win_opnd = opnd1;
      default: win_opnd = opnd2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d = 3'b001 << win_idx;
          opnd_d  = win_opnd;
          ptr_d   = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A completion in the timeout cycle still counts as a good result.
        if (core_done) begin
          res_d   = core_result;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StResp: begin
        grant_d = 3'b000;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      grant_q <= 3'b000;
      opnd_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign grant      = grant_q;
  assign core_start = (state_q == StIssue);
  assign core_a     = opnd_q[4*DW-1 -: DW];
  assign core_b     = opnd_q[3*DW-1 -: DW];
  assign core_c     = opnd_q[2*DW-1 -: DW];
  assign core_d     = opnd_q[DW-1:0];
  assign resp_valid = (state_q == StResp) ? grant_q : 3'b000;
  assign resp_data  = (state_q == StResp) ? res_q : '0;
  assign resp_err   = (state_q == StResp) & err_q;

endmodule

// File: tb/tb_minor_engine_arbiter.sv
// Scoreboard bench: expected responses are queued when requests are driven and
// matched against resp_valid pulses; a behavioural core computes a*d - b*c.
module tb_minor_engine_arbiter;

  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 64;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [2:0]      req   = 3'b000;
  logic [4*DW-1:0] opnd0 = '0;
  logic [4*DW-1:0] opnd1 = '0;
  logic [4*DW-1:0] opnd2 = '0;
  logic [2:0]      grant;
  logic            core_start;
  logic [DW-1:0]   core_a, core_b, core_c, core_d;
  logic            core_done   = 1'b0;
  logic [2*DW:0]   core_result = '0;
  logic [2:0]      resp_valid;
  logic [2*DW:0]   resp_data;
  logic            resp_err;

  minor_engine_arbiter #(.DW(DW), .TMO(TMO)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .opnd0      (opnd0),
    .opnd1      (opnd1),
    .opnd2      (opnd2),
    .grant      (grant),
    .core_start (core_start),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_c     (core_c),
    .core_d     (core_d),
    .core_done  (core_done),
    .core_result(core_result),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_resp   = 0;

  typedef struct {
    logic [2:0]    who;
    logic [2*DW:0] data;
    logic          err;
    int            at;
  } exp_t;
  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [2*DW:0] det(input logic [4*DW-1:0] op);
    logic signed [DW-1:0] a, b, c, d;
    int r;
    {a, b, c, d} = op;
    r = int'(a) * int'(d) - int'(b) * int'(c);
    return r[2*DW:0];
  endfunction

  // Behavioural core: completes done_delay cycles after core_start.
  int            done_delay    = 1;
  bit            core_silent   = 1'b0;
  bit            done_in_issue = 1'b0;
  bit            busy          = 1'b0;
  int            left          = 0;
  logic [2*DW:0] held          = '0;

  always @(negedge clock) begin
    core_done = 1'b0;
    if (!reset) begin
      busy = 1'b0;
    end else begin
      if (busy) begin
        left = left - 1;
        if (left == 0) begin
          core_done   = 1'b1;
          core_result = held;
          busy        = 1'b0;
        end
      end
      if (core_start && !core_silent) begin
        held = det({core_a, core_b, core_c, core_d});
        left = done_delay;
        busy = 1'b1;
        if (done_in_issue) begin
          core_done   = 1'b1;
          core_result = 17'h0F0F0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset && resp_valid != 3'b000) begin
      if (sb.size() == 0) begin
        check_eq("resp_spurious", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("resp_who", 32'(resp_valid), 32'(e.who));
        check_eq("resp_data", 32'(resp_data), 32'(e.data));
        check_eq("resp_err", 32'(resp_err), 32'(e.err));
        check_eq("resp_cycle", cyc, e.at);
      end
      n_resp++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [2:0] who, input logic [2*DW:0] data, input logic err,
                      input int at);
    exp_t e;
    e.who  = who;
    e.data = data;
    e.err  = err;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic wait_resp(input int target, input int budget);
    int n;
    n = 0;
    while (n_resp < target && n < budget) begin
      @(negedge clock);
      n++;
    end
    check_eq("resp_count", n_resp, target);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    req   = 3'b000;
    @(negedge clock);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_start", 32'(core_start), 32'd0);
    check_eq("rst_core_a", 32'(core_a), 32'd0);
    check_eq("rst_core_b", 32'(core_b), 32'd0);
    check_eq("rst_core_c", 32'(core_c), 32'd0);
    check_eq("rst_core_d", 32'(core_d), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_data", 32'(resp_data), 32'd0);
    check_eq("rst_resp_err", 32'(resp_err), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    idle(2);
  endtask

  // One request from an idle DUT; lat is cycles from the sampling cycle to resp_valid.
  task automatic single(input logic [2:0] r, input logic [2*DW:0] data, input logic err,
                        input int lat);
    int tgt;
    tgt = n_resp + 1;
    push(r, data, err, cyc + lat);
    req = r;
    wait_resp(tgt, lat + 10);
    req = 3'b000;
    idle(2);
  endtask

  task automatic pair(input logic [2:0] r, input logic [2:0] first, input logic [2*DW:0] d1,
                      input logic [2:0] second, input logic [2*DW:0] d2);
    int tgt;
    tgt = n_resp + 1;
    push(first, d1, 1'b0, cyc + 3);
    push(second, d2, 1'b0, cyc + 7);
    req = r;
    wait_resp(tgt, 20);
    req = second;
    wait_resp(tgt + 1, 20);
    req = 3'b000;
    idle(2);
  endtask

  initial begin
    int c, tgt;
    opnd0 = {8'd3, 8'd2, 8'd1, 8'd4};
    opnd1 = {8'h80, 8'h80, 8'h7F, 8'h80};
    opnd2 = {8'hFB, 8'h07, 8'h03, 8'hFE};
    do_reset();

    // Single request, core answers 3 cycles after start.
    done_delay = 3;
    c = cyc;
    tgt = n_resp + 1;
    push(3'b001, 17'd10, 1'b0, c + 5);
    req = 3'b001;
    @(negedge clock);
    check_eq("start_t1", 32'(core_start), 32'd1);
    check_eq("grant_issue", 32'(grant), 32'b001);
    check_eq("core_a_latched", 32'(core_a), 32'd3);
    check_eq("core_d_latched", 32'(core_d), 32'd4);
    @(negedge clock);
    check_eq("start_one_cycle", 32'(core_start), 32'd0);
    check_eq("grant_wait", 32'(grant), 32'b001);
    wait_resp(tgt, 20);
    req = 3'b000;
    idle(2);
    check_eq("grant_idle", 32'(grant), 32'd0);

    // Signed operands on the other requesters.
    done_delay = 1;
    single(3'b100, 17'h1FFF5, 1'b0, 3);
    single(3'b010, det(opnd1), 1'b0, 3);

    // Full contention.
    do_reset();
    done_delay = 2;
    c = cyc;
    tgt = n_resp + 4;
    push(3'b001, det(opnd0), 1'b0, c + 4);
    push(3'b010, det(opnd1), 1'b0, c + 9);
    push(3'b100, det(opnd2), 1'b0, c + 14);
    push(3'b001, det(opnd0), 1'b0, c + 19);
    req = 3'b111;
    wait_resp(tgt, 40);
    req = 3'b000;
    idle(2);

    // Fairness after pointer advance.
    do_reset();
    done_delay = 1;
    single(3'b010, det(opnd1), 1'b0, 3);
    pair(3'b011, 3'b001, det(opnd0), 3'b010, det(opnd1));

    // Watchdog expiry, done exactly at the timeout, done during ISSUE.
    core_silent = 1'b1;
    single(3'b001, 17'd0, 1'b1, 2 + TMO);
    core_silent = 1'b0;
    done_delay = TMO;
    single(3'b010, det(opnd1), 1'b0, 2 + TMO);
    done_in_issue = 1'b1;
    done_delay = 2;
    single(3'b100, det(opnd2), 1'b0, 4);
    done_in_issue = 1'b0;

    // Reset during WAIT aborts silently and clears the pointer.
    do_reset();
    done_delay = 10;
    req = 3'b010;
    idle(4);
    do_reset();
    done_delay = 1;
    single(3'b100, det(opnd2), 1'b0, 3);
    done_delay = 10;
    req = 3'b010;
    idle(4);
    do_reset();
    done_delay = 1;
    pair(3'b101, 3'b001, det(opnd0), 3'b100, det(opnd2));

    idle(3);
    check_eq("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
